// File: rtl/conv_result_writer_pkg.sv
// Shared types and helpers for the convolver result frame buffer.
// State encodings, address-width helper and output-size helper.
package conv_result_writer_pkg;

  typedef enum logic [1:0] {
    StIdle       = 2'b00,
    StWriteFrame = 2'b01,
    StReadFrame  = 2'b10
  } state_e;

  // Number of bits needed to count up to depth.
  function automatic int unsigned clogb2(input int unsigned depth);
    int unsigned d;
    int unsigned n;
    d = depth;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (d > 0) begin
        d = d >> 1;
        n = n + 1;
      end
    end
    return n;
  endfunction

  // Valid (unpadded) convolution output size along one axis.
  function automatic int unsigned out_dim(input int unsigned img, input int unsigned k);
    return img - k + 1;
  endfunction

  localparam int unsigned OUT_W   = out_dim(10, 3);
  localparam int unsigned OUT_H   = out_dim(10, 3);
  localparam int unsigned OUT_RES = OUT_W * OUT_H;

endpackage

// File: rtl/conv_result_writer_if.sv
// Pixel-in / frame-out handshake bundle of the convolver result writer.
// master drives the requests, slave is the frame buffer.
interface conv_result_writer_if #(
  parameter int unsigned RAM_WIDTH = 8
) ();

  logic                 i_start;
  logic                 i_valid_pixel;
  logic [RAM_WIDTH-1:0] i_pixel;
  logic                 o_busy;
  logic                 o_frame_done;
  logic                 i_valid_get_frame;
  logic                 o_is_frame_ready;
  logic [RAM_WIDTH-1:0] o_data_from_mem;
  logic                 o_valid_data;

  modport master (
    output i_start, i_valid_pixel, i_pixel, i_valid_get_frame,
    input  o_busy, o_frame_done, o_is_frame_ready, o_data_from_mem, o_valid_data
  );

  modport slave (
    input  i_start, i_valid_pixel, i_pixel, i_valid_get_frame,
    output o_busy, o_frame_done, o_is_frame_ready, o_data_from_mem, o_valid_data
  );

endinterface

// File: rtl/xilinx_single_port_ram_no_change.sv
// Single-port block RAM, no-change mode: the read latch holds while writing
// or while disabled. LOW_LATENCY gives 1-cycle reads, HIGH_PERFORMANCE 2.
module xilinx_single_port_ram_no_change
  import conv_result_writer_pkg::*;
#(
  parameter int unsigned RAM_WIDTH       = 18,
  parameter int unsigned RAM_DEPTH       = 1024,
  parameter string       RAM_PERFORMANCE = "LOW_LATENCY"
) (
  input  logic [clogb2(RAM_DEPTH-1)-1:0] addra,
  input  logic [RAM_WIDTH-1:0]           dina,
  input  logic                           clka,
  input  logic                           wea,
  input  logic                           ena,
  input  logic                           rsta,
  input  logic                           regcea,
  output logic [RAM_WIDTH-1:0]           douta
);

  logic [RAM_WIDTH-1:0] bram [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data;

  always_ff @(posedge clka) begin
    if (ena && wea) begin
      bram[addra] <= dina;
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      ram_data <= '0;
    end else if (ena && !wea) begin
      ram_data <= bram[addra];
    end
  end

  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
    // No output register to enable here; a disabled regcea reads as zero.
    assign douta = regcea ? ram_data : '0;
  end else begin : g_high_performance
    logic [RAM_WIDTH-1:0] douta_reg;
    always_ff @(posedge clka) begin
      if (rsta) begin
        douta_reg <= '0;
      end else if (regcea) begin
        douta_reg <= ram_data;
      end
    end
    assign douta = douta_reg;
  end

endmodule

// File: rtl/conv_result_writer.sv
// Frame buffer behind the convolver: stores column-major results at raster
// addresses, then streams the frame out in raster order on request.
module conv_result_writer
  import conv_result_writer_pkg::*;
#(
  parameter int unsigned RAM_WIDTH    = 8,
  parameter int unsigned RAM_DEPTH    = 2**16,
  parameter int unsigned IMAGE_WIDTH  = 10,
  parameter int unsigned IMAGE_HEIGHT = 10,
  parameter int unsigned KERNEL_WIDTH = 3
) (
  input logic                clk,
  input logic                reset,
  conv_result_writer_if.slave bus
);

  localparam int unsigned OutW   = out_dim(IMAGE_WIDTH, KERNEL_WIDTH);
  localparam int unsigned OutH   = out_dim(IMAGE_HEIGHT, KERNEL_WIDTH);
  localparam int unsigned OutRes = OutW * OutH;
  localparam int unsigned AW     = clogb2(RAM_DEPTH - 1);

  localparam logic [AW-1:0] RowStep = AW'(OutW);
  localparam logic [AW-1:0] ColLast = AW'(OutW - 1);
  localparam logic [AW-1:0] RowLast = AW'(OutH - 1);
  localparam logic [AW-1:0] RdLast  = AW'(OutRes - 1);

  if (OutRes > RAM_DEPTH) begin : g_bad_cfg
    $fatal(1, "conv_result_writer: output frame does not fit in RAM_DEPTH");
  end

  state_e               state_q, state_d;
  logic [AW-1:0]        col_q, col_d;
  logic [AW-1:0]        row_q, row_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic [AW-1:0]        rd_addr_q, rd_addr_d;
  logic [AW-1:0]        ram_addr_q, ram_addr_d;
  logic                 ram_we_q, ram_we_d;
  logic [RAM_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                 frame_done_q, frame_done_d;
  // [0]: address registered this cycle, [1]: RAM read latch holds the data.
  logic [1:0]           rd_pipe_q, rd_pipe_d;
  logic [RAM_WIDTH-1:0] ram_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_din_q    <= '0;
      frame_done_q <= 1'b0;
      rd_pipe_q    <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_din_q    <= ram_din_d;
      frame_done_q <= frame_done_d;
      rd_pipe_q    <= rd_pipe_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    ram_addr_d   = ram_addr_q;
    ram_we_d     = 1'b0;
    ram_din_d    = ram_din_q;
    frame_done_d = 1'b0;
    rd_pipe_d    = {rd_pipe_q[0], 1'b0};

    case (state_q)
      StIdle: begin
        if (bus.i_start) begin
          state_d   = StWriteFrame;
          col_d     = '0;
          row_d     = '0;
          wr_addr_d = '0;
          rd_addr_d = '0;
        end
      end
      StWriteFrame: begin
        if (bus.i_valid_pixel) begin
          ram_we_d   = 1'b1;
          ram_addr_d = wr_addr_q;
          ram_din_d  = bus.i_pixel;
          if (row_q == RowLast) begin
            // Bottom of a column: restart at the top of the next column.
            row_d     = '0;
            col_d     = col_q + 1'b1;
            wr_addr_d = col_q + 1'b1;
            if (col_q == ColLast) begin
              frame_done_d = 1'b1;
              state_d      = StReadFrame;
            end
          end else begin
            row_d     = row_q + 1'b1;
            wr_addr_d = wr_addr_q + RowStep;
          end
        end
      end
      StReadFrame: begin
        if (bus.i_valid_get_frame) begin
          ram_addr_d   = rd_addr_q;
          rd_addr_d    = rd_addr_q + 1'b1;
          rd_pipe_d[0] = 1'b1;
          if (rd_addr_q == RdLast) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Enable the RAM only for real accesses so the read latch holds the last pixel.
  xilinx_single_port_ram_no_change #(
    .RAM_WIDTH      (RAM_WIDTH),
    .RAM_DEPTH      (RAM_DEPTH),
    .RAM_PERFORMANCE("LOW_LATENCY")
  ) ram (
    .addra (ram_addr_q),
    .dina  (ram_din_q),
    .clka  (clk),
    .wea   (ram_we_q),
    .ena   (ram_we_q | rd_pipe_q[0]),
    .rsta  (reset),
    .regcea(1'b1),
    .douta (ram_dout)
  );

  assign bus.o_busy           = (state_q == StWriteFrame);
  assign bus.o_frame_done     = frame_done_q;
  assign bus.o_is_frame_ready = (state_q == StReadFrame);
  assign bus.o_valid_data     = rd_pipe_q[1];
  assign bus.o_data_from_mem  = ram_dout;

endmodule

// File: doc/conv_result_writer.md
Name: conv_result_writer

Overview:
Frame buffer on the output side of the convolver. The convolver produces one result pixel per kernel position in column-major order: the kernel steps down the rows, then moves one column right. This block writes each result into its own BRAM at the raster address of the (W-K+1)x(H-K+1) output image. It then serves the finished frame to the microblaze path one pixel per request, in raster order.

Parameters:
RAM_WIDTH, 8, pixel/data width in bits
RAM_DEPTH, 2**16, BRAM entries; must be >= OUT_W*OUT_H
IMAGE_WIDTH, 10, input image width W
IMAGE_HEIGHT, 10, input image height H
KERNEL_WIDTH, 3, kernel size K; derived OUT_W=W-K+1, OUT_H=H-K+1, OUT_RES=OUT_W*OUT_H

Ports:
clk  in  1  clock; one clock domain, all logic on rising edge
reset  in  1  synchronous, active-high reset
i_start  in  1  arm block for a new result frame (sampled in IDLE only)
i_valid_pixel  in  1  i_pixel holds a valid convolver result this cycle
i_pixel  in  RAM_WIDTH  convolver result pixel
o_busy  out  1  high in WRITE_FRAME
o_frame_done  out  1  one-cycle pulse when the last result pixel is accepted
i_valid_get_frame  in  1  request next output pixel (one pixel per high cycle)
o_is_frame_ready  out  1  high in READ_FRAME
o_data_from_mem  out  RAM_WIDTH  output pixel, raster order
o_valid_data  out  1  o_data_from_mem valid this cycle

Behaviour:
- Reset: state=IDLE; all counters, addresses, o_busy, o_frame_done, o_is_frame_ready, o_valid_data and o_data_from_mem are 0; RAM contents are not cleared.
- FSM states: IDLE(00), WRITE_FRAME(01), READ_FRAME(10); the encoding 11 is illegal and returns to IDLE.
- IDLE: i_valid_pixel and i_valid_get_frame are ignored. When i_start=1: clear col, row, col_base, wr_addr and rd_addr, then go to WRITE_FRAME.
- WRITE_FRAME, address generation (no multiplier):
  - Each accepted pixel (i_valid_pixel=1) is written to wr_addr.
  - Row step: row++, wr_addr += OUT_W.
  - When row==OUT_H-1 on an accepted pixel: row=0, col_base++, wr_addr=col_base+1.
  - Resulting mapping: address = row*OUT_W + col.
- Write path: wea, addra and dina are registered, so the RAM write completes one edge after acceptance. i_start is ignored in this state.
- Frame end: on acceptance of pixel number OUT_RES (col=OUT_W-1, row=OUT_H-1), o_frame_done=1 for the next cycle and the state becomes READ_FRAME. Pixels after that point are not accepted. Gaps of any length in i_valid_pixel are allowed.
- READ_FRAME: each cycle with i_valid_get_frame=1 registers addra=rd_addr and increments rd_addr.
- Read latency: RAM latency is 1 (LOW_LATENCY, regcea=1). o_valid_data and o_data_from_mem assert exactly 2 cycles after the request cycle, with one valid per request. Back-to-back requests give back-to-back data. o_data_from_mem holds its value between valids.
- Read end: the request for address OUT_RES-1 moves the state to IDLE. The two in-flight data beats are still delivered with o_valid_data. Requests after that point produce no valid.
- Reset mid-operation: the next edge returns to IDLE with all state cleared. A new frame needs i_start; partial frames are discarded.
- Widths: counters and addresses are clogb2(RAM_DEPTH-1) bits. Configurations with OUT_RES > RAM_DEPTH are illegal; a sim-only assertion checks this at elaboration.

Decomposition:
- Shared package/header: state encodings, the clogb2 function, and the derived constants OUT_W, OUT_H, OUT_RES.
- One sub-module: xilinx_single_port_ram_no_change (existing codebase BRAM), instantiated as ram with RAM_PERFORMANCE="LOW_LATENCY".
- The address generator stays inline in the FSM.

Test Plan:
- Reset: hold reset 3 cycles with random inputs -> all outputs 0, o_is_frame_ready=0, no o_valid_data.
- Full frame, 10x10, K=3 (OUT_RES=64): i_start, then 64 back-to-back pixels with value k=0..63 -> o_frame_done pulses once, the cycle after pixel 63. Then 64 consecutive requests -> readout 0,8,16,...,56,1,9,...,57,...,63, each exactly 2 cycles after its request.
- Gapped write: same 64 values with random 0-5 cycle gaps on i_valid_pixel -> identical readout; o_busy stays high throughout.
- Ignored traffic: 5 pixels and 3 get_frame pulses in IDLE, then the full frame, plus extra i_start pulses during WRITE_FRAME -> identical readout, no spurious o_valid_data.
- Reset mid-write: reset after 30 pixels, then i_start and a fresh 64-pixel frame with values 100+k -> readout 100,108,...,163 in transposed order.
- Spaced readout and end: requests every 3rd cycle -> data latency stays 2. After the 64th request: o_is_frame_ready=0 one cycle later, 2 trailing valids still delivered, a 65th request gives no valid.
